// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the asynchronous-memory initiator.
package mem_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_PULSE  = 3'd2,
    W_HOLD   = 3'd3,
    R_ACCESS = 3'd4,
    RESP     = 3'd5
  } state_t;

  // Idle-bus pin levels: deselected, read direction, output disabled
  localparam logic IDLE_CS = 1'b0;
  localparam logic IDLE_RD = 1'b1;
  localparam logic IDLE_OE = 1'b0;

  // Width of a down-counter able to hold the longer of the two timed phases
  function automatic int timer_width(input int wr_pulse, input int rd_wait);
    int longest;
    longest = (wr_pulse > rd_wait) ? wr_pulse : rd_wait;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/mem_ctrl_timer.sv
// Loadable phase down-counter with a zero flag; it parks at zero instead of wrapping.
module mem_ctrl_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load on phase entry, otherwise count down until zero and stay there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Synchronous initiator for a small asynchronous memory macro: sequences
// cs/rd/oe strobes with fixed setup/pulse/hold phases and returns responses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW       = 2,
  parameter int DW       = 3,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_is_rd,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_cs,
  output logic          mem_rd,
  output logic          mem_oe,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_i,
  input  logic [DW-1:0] mem_o
);

  localparam int TW = timer_width(WR_PULSE, RD_WAIT);

  state_t        state;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  mem_ctrl_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Requests are only taken while nothing is in flight
  assign req_ready = (state == IDLE);

  // Arm the phase timer on entry to the two multi-cycle phases
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (req_valid && !req_we) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(RD_WAIT - 1);
        end
      end
      W_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(WR_PULSE - 1);
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  // Sequencer and registered pin/response outputs, so every pin moves on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_cs    <= IDLE_CS;
      mem_rd    <= IDLE_RD;
      mem_oe    <= IDLE_OE;
      mem_a     <= '0;
      mem_i     <= '0;
      rsp_valid <= 1'b0;
      rsp_is_rd <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_a <= req_addr;
            mem_i <= req_wdata;
            if (req_we) begin
              state <= W_SETUP;
            end else begin
              state  <= R_ACCESS;
              mem_cs <= 1'b1;
              mem_rd <= 1'b1;
              mem_oe <= 1'b1;
            end
          end
        end
        W_SETUP: begin
          state  <= W_PULSE;
          mem_cs <= 1'b1;
          mem_rd <= 1'b0;
          mem_oe <= 1'b0;
        end
        W_PULSE: begin
          if (tmr_zero) begin
            state  <= W_HOLD;
            mem_cs <= IDLE_CS;
            mem_rd <= IDLE_RD;
          end
        end
        W_HOLD: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_is_rd <= 1'b0;
          rsp_rdata <= '0;
        end
        R_ACCESS: begin
          if (tmr_zero) begin
            state     <= RESP;
            rsp_rdata <= mem_o;
            rsp_valid <= 1'b1;
            rsp_is_rd <= 1'b1;
            mem_cs    <= IDLE_CS;
            mem_oe    <= IDLE_OE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_cs    <= IDLE_CS;
          mem_rd    <= IDLE_RD;
          mem_oe    <= IDLE_OE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl driving a behavioural 4x3 asynchronous memory.
module tb_mem_ctrl;

  localparam int AW       = 2;
  localparam int DW       = 3;
  localparam int WR_PULSE = 2;
  localparam int RD_WAIT  = 2;
  localparam int WR_LAT   = 2 + WR_PULSE;
  localparam int RD_LAT   = RD_WAIT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_is_rd;
  logic [DW-1:0] rsp_rdata;
  logic          mem_cs;
  logic          mem_rd;
  logic          mem_oe;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_i;
  wire  [DW-1:0] mem_o;

  int errors = 0;
  int checks = 0;

  // Reference contents of the memory, updated from the request stream alone
  int ref_mem [4];

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            hold;
    int            exp_is_rd;
    int            exp_rdata;
  } vec_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  vec_t vecs [11];
  req_t b2b [8];

  always #5 clk = ~clk;

  mem_ctrl #(
    .AW(AW), .DW(DW), .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_is_rd (rsp_is_rd),
    .rsp_rdata (rsp_rdata),
    .mem_cs    (mem_cs),
    .mem_rd    (mem_rd),
    .mem_oe    (mem_oe),
    .mem_a     (mem_a),
    .mem_i     (mem_i),
    .mem_o     (mem_o)
  );

  // Asynchronous memory macro: level-sensitive write, tri-stated read port
  logic [DW-1:0] mem_array [4];
  always @(mem_cs or mem_rd or mem_a or mem_i) begin
    if (mem_cs && !mem_rd) mem_array[mem_a] = mem_i;
  end
  assign mem_o = (mem_cs && mem_rd && mem_oe) ? mem_array[mem_a] : 3'bz;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Every-cycle bus rules: no address/data change around a write strobe, oe only during a read
  logic          prev_ok = 1'b0;
  logic          prev_cs, prev_rd;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_i;
  always @(negedge clk) begin
    if (rst) begin
      prev_ok <= 1'b0;
    end else begin
      if (prev_ok) begin
        checkOutput("bus_stable_in_strobe",
                    int'(((mem_a != prev_a) || (mem_i != prev_i)) &&
                         ((mem_cs && !mem_rd) || (prev_cs && !prev_rd))), 0);
      end
      checkOutput("bus_oe_qualified", int'(mem_oe && !(mem_cs && mem_rd)), 0);
      prev_cs <= mem_cs;
      prev_rd <= mem_rd;
      prev_a  <= mem_a;
      prev_i  <= mem_i;
      prev_ok <= 1'b1;
    end
  end

  // One request/response: accept, latency, response fields, optional back-pressure hold
  task automatic applyStimulus(input string tag, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input int hold,
                               input int exp_is_rd, input int exp_rdata);
    int n;
    int lat;
    int exp_lat;
    exp_lat = we ? WR_LAT : RD_LAT;
    @(negedge clk);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checkOutput({tag, "_accept_timeout"}, 0, 1);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput({tag, "_busy_ready"}, int'(req_ready), 0);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      checkOutput({tag, "_rsp_timeout"}, 0, 1);
      rsp_ready = 1'b1;
      return;
    end
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_is_rd"}, int'(rsp_is_rd), exp_is_rd);
    checkOutput({tag, "_rdata"}, int'(rsp_rdata), exp_rdata);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, int'(rsp_valid), 1);
      checkOutput({tag, "_hold_rdata"}, int'(rsp_rdata), exp_rdata);
      checkOutput({tag, "_hold_req_ready"}, int'(req_ready), 0);
      checkOutput({tag, "_hold_cs"}, int'(mem_cs), 0);
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    int exp_is_rd, exp_rdata;
    int acc, rsps, cyc, idx, last_rsp, e;
    bit pend;
    int exp_q [$];
    bit            r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    int            r_hold;

    for (int i = 0; i < 4; i++) ref_mem[i] = 0;

    vecs[0]  = '{1'b1, 2'd2, 3'b101, 0, 0, 0};
    vecs[1]  = '{1'b0, 2'd2, 3'd0,   0, 1, 5};
    vecs[2]  = '{1'b1, 2'd0, 3'd1,   0, 0, 0};
    vecs[3]  = '{1'b1, 2'd1, 3'd2,   0, 0, 0};
    vecs[4]  = '{1'b1, 2'd2, 3'd4,   0, 0, 0};
    vecs[5]  = '{1'b1, 2'd3, 3'd7,   0, 0, 0};
    vecs[6]  = '{1'b0, 2'd3, 3'd0,   0, 1, 7};
    vecs[7]  = '{1'b0, 2'd2, 3'd0,   0, 1, 4};
    vecs[8]  = '{1'b0, 2'd1, 3'd0,   0, 1, 2};
    vecs[9]  = '{1'b0, 2'd0, 3'd0,   0, 1, 1};
    vecs[10] = '{1'b0, 2'd1, 3'd0,   5, 1, 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_cs", int'(mem_cs), 0);
    checkOutput("rst_rd", int'(mem_rd), 1);
    checkOutput("rst_oe", int'(mem_oe), 0);
    checkOutput("rst_a", int'(mem_a), 0);
    checkOutput("rst_i", int'(mem_i), 0);
    checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rst_rsp_is_rd", int'(rsp_is_rd), 0);
    checkOutput("rst_rsp_rdata", int'(rsp_rdata), 0);
    checkOutput("rst_req_ready", int'(req_ready), 1);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) ref_mem[vecs[i].addr] = int'(vecs[i].wdata);
      applyStimulus($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].hold, vecs[i].exp_is_rd, vecs[i].exp_rdata);
    end

    // Randomised traffic against the reference memory
    for (int i = 0; i < 30; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 3));
      r_data = DW'($urandom_range(0, 7));
      r_hold = $urandom_range(0, 3);
      if (r_we) begin
        ref_mem[r_addr] = int'(r_data);
        exp_is_rd = 0;
        exp_rdata = 0;
      end else begin
        exp_is_rd = 1;
        exp_rdata = ref_mem[r_addr];
      end
      applyStimulus($sformatf("rnd%0d", i), r_we, r_addr, r_data, r_hold, exp_is_rd, exp_rdata);
    end

    // Back-to-back requests with req_valid held high
    for (int i = 0; i < 8; i++) begin
      b2b[i].we    = 1'($urandom_range(0, 1));
      b2b[i].addr  = AW'($urandom_range(0, 3));
      b2b[i].wdata = DW'($urandom_range(0, 7));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    idx = 0;
    req_we    = b2b[0].we;
    req_addr  = b2b[0].addr;
    req_wdata = b2b[0].wdata;
    req_valid = 1'b1;
    pend = 1'b0;
    acc = 0;
    rsps = 0;
    cyc = 0;
    last_rsp = -1;
    while (rsps < 8 && cyc < 400) begin
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < 8) begin
          req_we    = b2b[idx].we;
          req_addr  = b2b[idx].addr;
          req_wdata = b2b[idx].wdata;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("b2b_spurious_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("b2b_rsp", int'(rsp_is_rd) * 8 + int'(rsp_rdata), e);
        end
        rsps++;
        last_rsp = cyc;
      end
      if (req_valid && req_ready) begin
        if (last_rsp >= 0) checkOutput("b2b_throughput", cyc - last_rsp, 1);
        if (b2b[idx].we) begin
          ref_mem[b2b[idx].addr] = int'(b2b[idx].wdata);
          exp_q.push_back(0);
        end else begin
          exp_q.push_back(8 + ref_mem[b2b[idx].addr]);
        end
        acc++;
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    checkOutput("b2b_accepts", acc, 8);
    checkOutput("b2b_responses", rsps, 8);

    // Reset in the middle of a write strobe
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 2'd1;
    req_wdata = 3'd6;
    checkOutput("rstmid_ready", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_pulse_cs", int'(mem_cs), 1);
    checkOutput("rstmid_pulse_rd", int'(mem_rd), 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid_cs", int'(mem_cs), 0);
    checkOutput("rstmid_rd", int'(mem_rd), 1);
    checkOutput("rstmid_oe", int'(mem_oe), 0);
    checkOutput("rstmid_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rstmid_idle", int'(req_ready), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rstmid_no_rsp", int'(rsp_valid), 0);
      checkOutput("rstmid_idle_bus", int'(mem_cs), 0);
    end

    // Restore the interrupted location, then read everything back
    ref_mem[1] = 3;
    applyStimulus("restore", 1'b1, 2'd1, 3'd3, 0, 0, 0);
    for (int a = 0; a < 4; a++) begin
      applyStimulus($sformatf("final%0d", a), 1'b0, AW'(a), 3'd0, 0, 1, ref_mem[a]);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
